fmt_prot_chk: RTL and testbench

FMT_PROT_CHK -- requirements
Module: fmt_prot_chk

---
 rtl/fmt_prot_chk_if.sv | 28 ++
 rtl/fmt_prot_chk.sv | 108 ++++++++++
 tb/tb_fmt_prot_chk.sv | 119 +++++++++++
 3 files changed

// File: rtl/fmt_prot_chk_if.sv
// fmt_prot_chk_if: formatter handshake plus checker status bundle
interface fmt_prot_chk_if #(
    parameter int CH_NUM = 4,
    parameter int LEN_W  = 5,
    parameter int CNT_W  = 16
);
    localparam int CHW = $clog2(CH_NUM);
    logic             en_chk;
    logic             clr;
    logic             fmt_req;
    logic             fmt_grant;
    logic [CHW-1:0]   fmt_chid;
    logic [LEN_W-1:0] fmt_length;
    logic             fmt_start;
    logic             fmt_end;
    logic [6:0]       err_pulse;
    logic [6:0]       err_sticky;
    logic [CNT_W-1:0] err_cnt;
    logic             busy;
    modport master (
        output en_chk, clr, fmt_req, fmt_grant, fmt_chid, fmt_length, fmt_start, fmt_end,
        input  err_pulse, err_sticky, err_cnt, busy
    );
    modport slave (
        input  en_chk, clr, fmt_req, fmt_grant, fmt_chid, fmt_length, fmt_start, fmt_end,
        output err_pulse, err_sticky, err_cnt, busy
    );
endinterface

// File: rtl/fmt_prot_chk.sv
// fmt_prot_chk: formatter protocol checker; FMT_PROT_CHK_TIMEOUT_EN adds the grant timeout (bit 6)
module fmt_prot_chk #(
    parameter int CH_NUM      = 4,
    parameter int LEN_W       = 5,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 256
) (
    input logic clk,
    input logic rst,
    fmt_prot_chk_if.slave bus
);
    localparam int CHW = $clog2(CH_NUM);
    typedef enum logic [1:0] {IDLE, WAIT_GNT, GNT1, XFER} state_t;
    state_t state_q, state_d;
    logic req_p_q, gnt_p_q, start_p_q, end_p_q;
    logic [CHW-1:0] chid_q, chid_d;
    logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d, beat;
    logic unst_q, unst_d;
    logic [6:0] err_d, pulse_q, sticky_q;
    logic [CNT_W-1:0] ecnt_q;
    logic req_rise, gnt_rise, mism, tmo;
    assign req_rise = bus.fmt_req & ~req_p_q;
    assign gnt_rise = bus.fmt_grant & ~gnt_p_q;
    assign beat = cnt_q + 1'b1;
    assign mism = state_q != IDLE && (bus.fmt_chid != chid_q || bus.fmt_length != len_q);
`ifdef FMT_PROT_CHK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tcnt_q;
    assign tmo = state_q == WAIT_GNT && bus.fmt_req && !gnt_rise && tcnt_q == TW'(TIMEOUT_CYC - 1);
    always_ff @(posedge clk)
        tcnt_q <= (rst || state_q != WAIT_GNT) ? '0 : tcnt_q + 1'b1;
`else
    assign tmo = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            req_p_q   <= 1'b0;
            gnt_p_q   <= 1'b0;
            start_p_q <= 1'b0;
            end_p_q   <= 1'b0;
            chid_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            unst_q    <= 1'b0;
            pulse_q   <= '0;
            sticky_q  <= '0;
            ecnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            req_p_q   <= bus.fmt_req;
            gnt_p_q   <= bus.fmt_grant;
            start_p_q <= bus.fmt_start;
            end_p_q   <= bus.fmt_end;
            chid_q    <= chid_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            unst_q    <= unst_d;
            pulse_q   <= err_d;
            sticky_q  <= bus.clr ? err_d : sticky_q | err_d;
            ecnt_q    <= bus.clr ? CNT_W'(|err_d) : (|err_d && ecnt_q != '1) ? ecnt_q + 1'b1 : ecnt_q;
        end
    end
    always_comb begin
        state_d = state_q;
        chid_d  = chid_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        unst_d  = unst_q | mism;
        case (state_q)
            IDLE: if (req_rise) begin
                chid_d  = bus.fmt_chid;
                len_d   = bus.fmt_length;
                unst_d  = 1'b0;
                state_d = bus.fmt_length == '0 ? IDLE : WAIT_GNT;
            end
            WAIT_GNT: state_d = gnt_rise ? GNT1 : (!bus.fmt_req || tmo) ? IDLE : WAIT_GNT;
            GNT1: begin
                cnt_d   = LEN_W'(1);
                state_d = (!bus.fmt_start || bus.fmt_end) ? IDLE : XFER;
            end
            default: begin
                cnt_d   = beat;
                state_d = (bus.fmt_end || beat >= len_q) ? IDLE : XFER;
            end
        endcase
        if (!bus.en_chk) state_d = IDLE;
    end
    // an end strobe on the first beat is only legal for single-beat packets
    always_comb begin
        err_d = '0;
        bus.busy = state_q != IDLE;
        if (bus.en_chk) begin
            err_d[0] = state_q == GNT1 && bus.fmt_req;
            err_d[1] = state_q == GNT1 && !bus.fmt_start;
            err_d[2] = bus.fmt_start && start_p_q;
            err_d[3] = bus.fmt_end && end_p_q;
            err_d[4] = mism && !unst_q;
            err_d[5] = (state_q == IDLE && req_rise && bus.fmt_length == '0)
                || (state_q == GNT1 && bus.fmt_start && bus.fmt_end && len_q != LEN_W'(1))
                || (state_q == XFER && (bus.fmt_end ? beat != len_q : beat >= len_q));
            err_d[6] = tmo;
        end
    end
    assign bus.err_pulse  = pulse_q;
    assign bus.err_sticky = sticky_q;
    assign bus.err_cnt    = ecnt_q;
endmodule

// File: tb/tb_fmt_prot_chk.sv
// tb_fmt_prot_chk: directed checks of fmt_prot_chk, timeout expectations follow FMT_PROT_CHK_TIMEOUT_EN
module tb_fmt_prot_chk;
    logic clk = 1'b0;
    logic rst;
    int n_cmp = 0;
    int n_bad = 0;
`ifdef FMT_PROT_CHK_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif
    always #5 clk = ~clk;
    fmt_prot_chk_if #(.CH_NUM(4), .LEN_W(5), .CNT_W(3)) bus ();
    fmt_prot_chk #(.CH_NUM(4), .LEN_W(5), .CNT_W(3), .TIMEOUT_CYC(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic st(input string tag, input logic [6:0] p, input logic [6:0] s, input logic [2:0] c, input logic b);
        chk({tag, ".pulse"}, 32'(bus.err_pulse), 32'(p));
        chk({tag, ".sticky"}, 32'(bus.err_sticky), 32'(s));
        chk({tag, ".cnt"}, 32'(bus.err_cnt), 32'(c));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(b));
    endtask
    task automatic drv(input logic req, input logic gnt, input logic sta, input logic fin, input logic [1:0] chid, input logic [4:0] len);
        bus.fmt_req    = req;
        bus.fmt_grant  = gnt;
        bus.fmt_start  = sta;
        bus.fmt_end    = fin;
        bus.fmt_chid   = chid;
        bus.fmt_length = len;
    endtask
    initial begin
        bus.en_chk = 1'b1;
        bus.clr = 1'b0;
        rst = 1'b1;
        drv(1, 0, 0, 0, 2, 4);
        tick(2);
        st("reset", 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        chk("rise_after_rst", 32'(bus.busy), 1);
        drv(1, 1, 0, 0, 2, 4); tick(); st("legal_gnt", 0, 0, 0, 1);
        drv(0, 1, 1, 0, 2, 4); tick(); st("legal_b1", 0, 0, 0, 1);
        drv(0, 1, 0, 0, 2, 4); tick(2); st("legal_b3", 0, 0, 0, 1);
        drv(0, 1, 0, 1, 2, 4); tick(); st("legal_end", 0, 0, 0, 0);
        drv(0, 0, 0, 0, 2, 4); tick(); st("legal_idle", 0, 0, 0, 0);
        drv(1, 0, 0, 0, 1, 2); tick();
        drv(1, 1, 0, 0, 1, 2); tick();
        drv(1, 1, 1, 0, 1, 2); tick(); st("req_hold", 7'h01, 7'h01, 1, 1);
        drv(0, 1, 0, 1, 1, 2); tick(); st("req_hold_done", 0, 7'h01, 1, 0);
        drv(0, 0, 0, 0, 1, 2); bus.clr = 1'b1; tick(); bus.clr = 1'b0;
        st("clr", 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 4); tick();
        drv(1, 1, 0, 0, 0, 4); tick();
        drv(0, 1, 1, 0, 0, 4); tick();
        drv(0, 1, 0, 0, 0, 4); tick();
        drv(0, 1, 0, 1, 0, 4); tick(); st("len_early", 7'h20, 7'h20, 1, 0);
        drv(0, 0, 0, 0, 0, 1); tick();
        drv(1, 0, 0, 0, 0, 1); tick();
        drv(1, 1, 0, 0, 0, 1); tick();
        drv(0, 1, 1, 1, 0, 1); tick(); st("clean_len1", 0, 7'h20, 1, 0);
        drv(0, 0, 0, 0, 0, 1); bus.clr = 1'b1; tick(); bus.clr = 1'b0;
        drv(1, 0, 0, 0, 2, 4); tick();
        drv(1, 1, 0, 0, 2, 4); tick();
        drv(0, 1, 1, 0, 2, 4); tick(); st("su_b1", 0, 0, 0, 1);
        drv(0, 1, 1, 0, 3, 4); tick(); st("start_unst", 7'h14, 7'h14, 1, 1);
        drv(0, 1, 0, 0, 3, 4); tick(); st("unst_once", 0, 7'h14, 1, 1);
        drv(0, 1, 0, 1, 3, 4); tick(); st("unst_end", 0, 7'h14, 1, 0);
        tick(); st("end_pulse", 7'h08, 7'h1c, 2, 0);
        drv(0, 0, 0, 0, 0, 2); bus.clr = 1'b1; tick(); bus.clr = 1'b0;
        drv(1, 0, 0, 0, 0, 2); tick();
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("tmo_quiet", 32'(bus.err_pulse[6]), 0);
        end
        tick(); st("timeout", {TMO, 6'd0}, {TMO, 6'd0}, {2'd0, TMO}, !TMO);
        drv(0, 0, 0, 0, 0, 2); tick(); chk("tmo_idle", 32'(bus.busy), 0);
        drv(1, 0, 0, 0, 1, 2); tick();
        drv(1, 1, 0, 0, 1, 2); tick();
        drv(0, 1, 0, 0, 1, 2); tick(); st("no_start", 7'h02, {TMO, 6'h02}, TMO ? 3'd2 : 3'd1, 0);
        drv(0, 0, 0, 0, 1, 2); tick();
        drv(1, 0, 0, 0, 1, 0); bus.clr = 1'b1; tick(); bus.clr = 1'b0;
        st("clr_len", 7'h20, 7'h20, 1, 0);
        drv(0, 0, 0, 0, 1, 2); tick();
        bus.clr = 1'b1; tick(); bus.clr = 1'b0;
        drv(0, 0, 1, 0, 0, 2);
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("sat_cnt", 32'(bus.err_cnt), k - 1 > 7 ? 7 : k - 1);
        end
        bus.en_chk = 1'b0;
        drv(1, 0, 1, 0, 0, 2); tick(); st("dis", 0, 7'h04, 7, 0);
        tick(); st("dis2", 0, 7'h04, 7, 0);
        bus.en_chk = 1'b1;
        drv(0, 0, 0, 0, 0, 2); tick(); st("reen", 0, 7'h04, 7, 0);
        drv(1, 0, 0, 0, 2, 3); tick();
        drv(1, 1, 0, 0, 2, 3); tick(); chk("mid_busy", 32'(bus.busy), 1);
        rst = 1'b1;
        drv(0, 1, 0, 0, 2, 3); tick(); st("rst_mid", 0, 0, 0, 0);
        rst = 1'b0;
        drv(0, 0, 0, 0, 2, 3); tick(); st("post_rst", 0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
